// File: rtl/dpc_pkg.sv
// Shared types and constants for the Dekatron PC I/O path.
package dpc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int   UART_DATA_BITS = 8;
  localparam logic LINE_IDLE      = 1'b1;

endpackage

// File: rtl/dpc_fifo.sv
// Generic synchronous FIFO; push is ignored when full and pop when empty.
module dpc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dpc_out_uart.sv
// Output stage: buffers core characters in a FIFO and sends them as 8N1 UART frames.
module dpc_out_uart
  import dpc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       CLOCK,
  input  logic       RST_N,
  input  logic [7:0] OUT_DATA,
  input  logic       OUT_VALID,
  output logic       OUT_READY,
  output logic       TX,
  output logic       BUSY
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam int                BIT_W     = $clog2(UART_DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

  uart_state_t               state, state_n;
  logic [BAUD_W-1:0]         baud, baud_n;
  logic [BIT_W-1:0]          bit_idx, bit_n;
  logic [UART_DATA_BITS-1:0] shift, shift_n;
  logic                      tx, tx_n;
  logic                      pop;
  logic                      push;
  logic [7:0]                head;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic                      full;
  logic                      empty;

  dpc_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLOCK),
    .rst_n (RST_N),
    .push  (push),
    .din   (OUT_DATA),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign OUT_READY = !full;
  assign push      = OUT_VALID && OUT_READY;
  assign BUSY      = (state != IDLE) || (count != '0);
  assign TX        = tx;

  always_ff @(posedge CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= LINE_IDLE;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      tx      <= tx_n;
    end
  end

  // tx_n is the line level for the cycle after this edge, so TX stays registered.
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    shift_n = shift;
    tx_n    = tx;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        tx_n = LINE_IDLE;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          baud_n  = '0;
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (baud == BAUD_LAST) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
          tx_n    = shift[0];
        end else begin
          baud_n = baud + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud == BAUD_LAST) begin
          baud_n = '0;
          if (bit_idx == BIT_LAST) begin
            state_n = STOP;
            tx_n    = LINE_IDLE;
          end else begin
            shift_n = shift >> 1;
            bit_n   = bit_idx + BIT_W'(1);
            tx_n    = shift[1];
          end
        end else begin
          baud_n = baud + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud == BAUD_LAST) begin
          baud_n = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_n = head;
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = LINE_IDLE;
          end
        end else begin
          baud_n = baud + BAUD_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = LINE_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dpc_out_uart.sv
// Directed bench: accepted characters go to a scoreboard, a line monitor decodes TX frames and compares.
module tb_dpc_out_uart;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       CLOCK;
  logic       RST_N;
  logic [7:0] OUT_DATA;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic       TX;
  logic       BUSY;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  int         frames = 0;
  logic [7:0] sb[$];
  int         starts[$];

  bit          mon_active = 1'b0;
  int unsigned mon_cyc;
  int unsigned mon_idx;
  int unsigned mon_pos;
  bit          mon_ok;
  logic [7:0]  mon_byte;
  logic [7:0]  mon_exp;

  dpc_out_uart #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .CLOCK     (CLOCK),
    .RST_N     (RST_N),
    .OUT_DATA  (OUT_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .TX        (TX),
    .BUSY      (BUSY)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line monitor: a frame is 10*CPB cycles; every cycle of each bit must hold the same level.
  always @(negedge CLOCK) begin
    if (RST_N !== 1'b1) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && TX === 1'b0) begin
        mon_active = 1'b1;
        mon_cyc    = 0;
        mon_ok     = 1'b1;
        mon_byte   = '0;
        starts.push_back(cyc);
      end
      if (mon_active) begin
        mon_idx = mon_cyc / CPB;
        mon_pos = mon_cyc % CPB;
        if (mon_idx == 0) begin
          if (TX !== 1'b0) mon_ok = 1'b0;
        end else if (mon_idx == 9) begin
          if (TX !== 1'b1) mon_ok = 1'b0;
        end else if (mon_pos == 0) begin
          mon_byte[mon_idx-1] = TX;
        end else if (TX !== mon_byte[mon_idx-1]) begin
          mon_ok = 1'b0;
        end
        mon_cyc++;
        if (mon_cyc == 10 * CPB) begin
          mon_active = 1'b0;
          frames++;
          if (sb.size() == 0) begin
            check("unexpected_frame", {23'd0, mon_ok, mon_byte}, 32'hFFFF_FFFF);
          end else begin
            mon_exp = sb.pop_front();
            check("frame_byte", {23'd0, mon_ok, mon_byte}, {23'd0, 1'b1, mon_exp});
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, output int t);
    int n;
    n = 0;
    OUT_DATA  = b;
    OUT_VALID = 1'b1;
    while (OUT_READY !== 1'b1 && n < 500) begin
      @(posedge CLOCK);
      #1;
      n++;
    end
    if (OUT_READY !== 1'b1) begin
      check("ready_timeout", {31'd0, OUT_READY}, 1);
      t = cyc;
    end else begin
      @(posedge CLOCK);
      sb.push_back(b);
      #1;
      t = cyc;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge CLOCK);
      n++;
    end while ((BUSY !== 1'b0 || mon_active || TX !== 1'b1) && n < 2000);
    check("drain_busy", {31'd0, BUSY}, 0);
  endtask

  task automatic check_gaps(input string tag);
    for (int unsigned i = 1; i < starts.size(); i++)
      check(tag, starts[i] - starts[i-1], 10 * CPB);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t6, tn, td, tr, f0, bad, n;
    RST_N     = 1'b0;
    OUT_VALID = 1'b0;
    OUT_DATA  = '0;
    #23;
    check("rst_tx", {31'd0, TX}, 1);
    check("rst_ready", {31'd0, OUT_READY}, 1);
    check("rst_busy", {31'd0, BUSY}, 0);
    @(negedge CLOCK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLOCK);

    // Single frame 0x48
    starts.delete();
    f0 = frames;
    send(8'h48, t0);
    OUT_VALID = 1'b0;
    check("single_busy_rise", {31'd0, BUSY}, 1);
    check("single_tx_hold", {31'd0, TX}, 1);
    @(posedge CLOCK);
    #1;
    check("single_tx_start", {31'd0, TX}, 0);
    n = 0;
    while (BUSY === 1'b1 && n < 500) begin
      @(posedge CLOCK);
      #1;
      n++;
    end
    check("single_busy_len", cyc - t0, 41);
    wait_idle();
    check("single_frames", frames - f0, 1);
    check("single_start_time", (starts.size() > 0) ? starts[0] : -1, t0 + 1);

    // Fill, back-pressure and valid-while-not-ready
    starts.delete();
    f0 = frames;
    send(8'h01, t1);
    send(8'h02, tn);
    send(8'h03, tn);
    send(8'h04, tn);
    send(8'h05, tn);
    check("fill_accept5_time", tn - t1, 4);
    check("fill_ready_low", {31'd0, OUT_READY}, 0);
    OUT_DATA = 8'hEE;
    bad = 0;
    repeat (10) begin
      @(posedge CLOCK);
      #1;
      if (OUT_READY !== 1'b0) bad++;
    end
    check("stall_ready_low", bad, 0);
    send(8'h06, t6);
    OUT_VALID = 1'b0;
    check("fill_sixth_accept", t6 - t1, 42);
    wait_idle();
    check("fill_frames", frames - f0, 6);
    check_gaps("fill_gap");

    // Push landing on the STOP-end pop edge with count 2
    starts.delete();
    f0 = frames;
    send(8'hC3, t0);
    send(8'h3C, tn);
    send(8'h96, tn);
    OUT_VALID = 1'b0;
    check("sim_ready_count2", {31'd0, OUT_READY}, 1);
    n = 0;
    while (cyc < t0 + 40 && n < 100) begin
      @(posedge CLOCK);
      #1;
      n++;
    end
    send(8'h69, td);
    OUT_VALID = 1'b0;
    check("sim_push_edge", td - t0, 41);
    wait_idle();
    check("sim_frames", frames - f0, 4);
    check("sim_second_start", (starts.size() > 1) ? starts[1] : -1, t0 + 41);
    check_gaps("sim_gap");

    // Asynchronous reset during data bit 3, with two characters still queued
    f0 = frames;
    send(8'hA5, tr);
    send(8'h11, tn);
    send(8'h22, tn);
    OUT_VALID = 1'b0;
    n = 0;
    while (cyc < tr + 18 && n < 100) begin
      @(posedge CLOCK);
      #1;
      n++;
    end
    check("mid_bit3_low", {31'd0, TX}, 0);
    RST_N = 1'b0;
    #1;
    check("arst_tx", {31'd0, TX}, 1);
    check("arst_ready", {31'd0, OUT_READY}, 1);
    check("arst_busy", {31'd0, BUSY}, 0);
    sb.delete();
    @(negedge CLOCK);
    @(negedge CLOCK);
    RST_N = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge CLOCK);
      if (TX !== 1'b1 || BUSY !== 1'b0) bad++;
    end
    check("post_rst_idle", bad, 0);
    check("post_rst_no_frame", frames - f0, 0);
    starts.delete();
    send(8'h55, t0);
    OUT_VALID = 1'b0;
    wait_idle();
    check("post_rst_frames", frames - f0, 1);
    check("post_rst_start", (starts.size() > 0) ? starts[0] : -1, t0 + 1);

    // Pointer wrap-around: nine characters through a four-entry FIFO
    starts.delete();
    f0 = frames;
    for (int unsigned i = 0; i < 9; i++) send(8'($urandom_range(0, 255)), tn);
    OUT_VALID = 1'b0;
    wait_idle();
    check("wrap_frames", frames - f0, 9);
    check_gaps("wrap_gap");

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpc_out_uart.md
# dpc_out_uart

Output stage of the Dekatron PC: it consumes the character stream the core emits on its output port and serialises it as 8N1 UART frames on a single TX line. A small FIFO absorbs bursts from consecutive output instructions. A valid/ready handshake back-pressures the core while the FIFO is full. The block sits directly downstream of the `dekatronpc` top and shares its single clock domain.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per UART bit; legal range 2..65535.
- `FIFO_DEPTH`, default 4: number of FIFO entries; must be a power of two, 2..16.

- `CLOCK`  in  1  system clock; all logic is on the rising edge.
- `RST_N`  in  1  reset. One clock; reset is asynchronous and active-low.
- `OUT_DATA`  in  8  character from the core (low byte of the core's OUT word).
- `OUT_VALID`  in  1  core presents `OUT_DATA` this cycle.
- `OUT_READY`  out  1  FIFO can accept a character; high when FIFO count < `FIFO_DEPTH`.
- `TX`  out  1  UART line; idles high.
- `BUSY`  out  1  high when a frame is in progress or the FIFO is non-empty.

## Operation
- **Accept:** a push occurs on an edge where `OUT_VALID && OUT_READY`. `OUT_DATA` is written at the tail. `OUT_VALID` while `OUT_READY` is low is ignored and nothing is written; the core must hold its data.
- **`OUT_READY`:** combinational from the registered FIFO count. A pop on edge N frees a slot, so `OUT_READY` is visible high after edge N.
- **Simultaneous push and pop:** allowed at any non-full count, and count is unchanged. At full count, only the pop occurs.
- **FSM states:** IDLE, START, DATA, STOP. A bit counter (0..7) and a baud counter (0..`CLKS_PER_BIT`-1) are used.
  - **IDLE:** TX=1. If count≠0: pop the head into the shift register, reset the baud counter, and go to START.
  - **START:** TX=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit=0.
  - **DATA:** TX=shift[0], LSB first. After `CLKS_PER_BIT` cycles, shift right and increment bit. After bit 7 completes, go to STOP.
  - **STOP:** TX=1 for `CLKS_PER_BIT` cycles. At the end, if count≠0, pop and go directly to START with no idle gap; otherwise go to IDLE.
- **TX register:** TX is a registered output with no combinational path from inputs.
- **Reset:** asynchronous assertion at any point, including mid-frame. TX=1, `BUSY`=0, FIFO flushed (count=0, pointers 0), `OUT_READY`=1, state IDLE. A truncated frame is not resumed. After release the block is idle until the next push.
- **Pointers:** wrap modulo `FIFO_DEPTH`. Count width is clog2(`FIFO_DEPTH`)+1 so that full and empty are distinct.

## Timing
- **Push to TX falling edge:** the character accepted on edge N is popped on edge N+1 if the FIFO was empty and the FSM was IDLE. TX goes low after edge N+1.
- **Frame length:** exactly 10×`CLKS_PER_BIT` cycles. Back-to-back frames are contiguous.
- **`BUSY`:** rises after the accepting edge. It falls after the edge that ends the last STOP bit with the FIFO empty.
- **Throughput:** one character per 10×`CLKS_PER_BIT` cycles. Sustained core output faster than that fills the FIFO and deasserts `OUT_READY`.

## Structure
- **Shared package `dpc_pkg`:** holds the `uart_state_t` enum (IDLE/START/DATA/STOP), the `UART_DATA_BITS`=8 constant, and the idle line level constant.
- **Sub-module `dpc_fifo`:** a generic synchronous FIFO (parameters WIDTH and DEPTH; push, pop, data in/out, count, full, empty). It is reusable for the input path.
- **Top `dpc_out_uart`:** the FSM, the counters and the shift register.

## Test plan
- **Single frame:** reset, then `CLKS_PER_BIT`=4 and push 0x48 once. TX is low for 4 cycles starting 1 cycle after the push, then carries bits 0,0,0,1,0,0,1,0 (4 cycles each), then high for 4 cycles. `BUSY` is high for 41 cycles in total.
- **Fill / back-pressure:** `OUT_VALID` held high with 0x01..0x06. The first character is popped immediately. `OUT_READY` falls after the 5th accept. 0x06 is held until the first frame's STOP bit ends and the next pop frees a slot. All 6 characters appear in order with no idle gaps.
- **Valid while not ready:** at full, change `OUT_DATA` while `OUT_READY`=0. No write occurs and only the held value is transmitted.
- **Simultaneous push and pop:** count=2, and a push lands on the same edge as the STOP end. Count stays 2 and the order is preserved.
- **Reset mid-frame:** assert `RST_N`=0 during DATA bit 3. TX is 1 immediately (asynchronous), `OUT_READY`=1, `BUSY`=0. After release, a push of 0x55 produces a clean frame with no leftover data.
- **Wrap-around:** push 9 characters with `FIFO_DEPTH`=4 while draining. The pointers wrap and the output sequence matches the input exactly.
